// File: rtl/vector_arbiter.sv
// vector_arbiter: serialises get/insert transactions from two requesters onto one shared vector.
// Optional macro VECTOR_ARBITER_RR_EN selects round-robin tie-breaking; default is fixed priority to A.
module vector_arbiter #(
    parameter int DATA_WIDTH     = 17,
    parameter int INDEX_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_req,
    input  logic                   a_insert,
    input  logic [INDEX_WIDTH-1:0] a_index,
    input  logic [DATA_WIDTH-1:0]  a_data_in,
    output logic                   a_grant,
    output logic                   a_done,
    input  logic                   b_req,
    input  logic                   b_insert,
    input  logic [INDEX_WIDTH-1:0] b_index,
    input  logic [DATA_WIDTH-1:0]  b_data_in,
    output logic                   b_grant,
    output logic                   b_done,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [INDEX_WIDTH-1:0] vec_index,
    output logic                   vec_get,
    output logic                   vec_insert,
    output logic [DATA_WIDTH-1:0]  vec_data_in,
    input  logic [DATA_WIDTH-1:0]  vec_data_out,
    input  logic                   vec_ready,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_insert_q, op_insert_d;
    logic [INDEX_WIDTH-1:0] vec_index_q, vec_index_d;
    logic [DATA_WIDTH-1:0]  vec_data_in_q, vec_data_in_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   vec_get_q, vec_get_d;
    logic                   vec_insert_q, vec_insert_d;
    logic                   a_grant_q, a_grant_d, b_grant_q, b_grant_d;
    logic                   a_done_q, a_done_d, b_done_q, b_done_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;

    logic grant_fire;
    logic pick_b;

    assign grant_fire = (state_q == ST_IDLE) & vec_ready & (a_req | b_req);

`ifdef VECTOR_ARBITER_RR_EN
    logic last_b_q;  // 1 = B won the most recent grant; reset value lets A win the first tie

    assign pick_b = b_req & (~a_req | ~last_b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          last_b_q <= 1'b1;
        else if (grant_fire) last_b_q <= pick_b;
    end
`else
    assign pick_b = b_req & ~a_req;
`endif

    always_comb begin
        // NOTE: every _d defaults to its _q (strobes and dones to 0) so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_insert_d   = op_insert_q;
        vec_index_d   = vec_index_q;
        vec_data_in_d = vec_data_in_q;
        data_out_d    = data_out_q;
        vec_get_d     = 1'b0;
        vec_insert_d  = 1'b0;
        a_grant_d     = a_grant_q;
        b_grant_d     = b_grant_q;
        a_done_d      = 1'b0;
        b_done_d      = 1'b0;
        timeout_d     = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_fire) begin
                    op_insert_d   = pick_b ? b_insert  : a_insert;
                    vec_index_d   = pick_b ? b_index   : a_index;
                    vec_data_in_d = pick_b ? b_data_in : a_data_in;
                    vec_insert_d  = pick_b ? b_insert  : a_insert;
                    vec_get_d     = pick_b ? ~b_insert : ~a_insert;
                    a_grant_d     = ~pick_b;
                    b_grant_d     = pick_b;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_SETTLE;
            ST_SETTLE: begin
                // The vector is still registering the strobe, so ready is not trusted here.
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (vec_ready || (cnt_q == CNT_LAST)) begin
                    if (vec_ready && !op_insert_q) data_out_d = vec_data_out;
                    if (!vec_ready)                timeout_d  = 1'b1;
                    a_done_d  = a_grant_q;
                    b_done_d  = b_grant_q;
                    a_grant_d = 1'b0;
                    b_grant_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: datapath registers are reset too, since every output must read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_insert_q   <= 1'b0;
            vec_index_q   <= '0;
            vec_data_in_q <= '0;
            data_out_q    <= '0;
            vec_get_q     <= 1'b0;
            vec_insert_q  <= 1'b0;
            a_grant_q     <= 1'b0;
            b_grant_q     <= 1'b0;
            a_done_q      <= 1'b0;
            b_done_q      <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_insert_q   <= op_insert_d;
            vec_index_q   <= vec_index_d;
            vec_data_in_q <= vec_data_in_d;
            data_out_q    <= data_out_d;
            vec_get_q     <= vec_get_d;
            vec_insert_q  <= vec_insert_d;
            a_grant_q     <= a_grant_d;
            b_grant_q     <= b_grant_d;
            a_done_q      <= a_done_d;
            b_done_q      <= b_done_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
        end
    end

    assign a_grant     = a_grant_q;
    assign b_grant     = b_grant_q;
    assign a_done      = a_done_q;
    assign b_done      = b_done_q;
    assign data_out    = data_out_q;
    assign vec_index   = vec_index_q;
    assign vec_data_in = vec_data_in_q;
    assign vec_get     = vec_get_q;
    assign vec_insert  = vec_insert_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_vector_arbiter.sv
// Self-checking bench for vector_arbiter: table vectors, tie/timeout/reset sequences and random
// transactions checked against a behavioural vector + arbitration model.
module tb_vector_arbiter;

    localparam int DW = 17;
    localparam int IW = 8;
    localparam int TO = 8;
`ifdef VECTOR_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_req = 1'b0, a_insert = 1'b0, b_req = 1'b0, b_insert = 1'b0;
    logic [IW-1:0] a_index = '0, b_index = '0;
    logic [DW-1:0] a_data_in = '0, b_data_in = '0;
    logic a_grant, a_done, b_grant, b_done, vec_get, vec_insert, vec_ready, busy, timeout_err;
    logic [DW-1:0] data_out, vec_data_in, vec_data_out;
    logic [IW-1:0] vec_index;

    always #5 clk = ~clk;

    vector_arbiter #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_insert(a_insert), .a_index(a_index), .a_data_in(a_data_in),
        .a_grant(a_grant), .a_done(a_done),
        .b_req(b_req), .b_insert(b_insert), .b_index(b_index), .b_data_in(b_data_in),
        .b_grant(b_grant), .b_done(b_done),
        .data_out(data_out), .vec_index(vec_index), .vec_get(vec_get), .vec_insert(vec_insert),
        .vec_data_in(vec_data_in), .vec_data_out(vec_data_out), .vec_ready(vec_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Vector model: ready returns vm_lat cycles after the strobe cycle (lat 1 = never drops).
    logic [DW-1:0] vm_mem [256];
    logic          vm_rdy;
    int            vm_cnt;
    logic [DW-1:0] vm_dout;
    int            vm_lat = 2;
    bit            vm_stuck = 1'b0;
    bit            vm_block = 1'b0;

    assign vec_ready    = vm_rdy & ~vm_block;
    assign vec_data_out = vm_dout;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) vm_mem[i] <= '0;
            vm_rdy  <= 1'b1;
            vm_cnt  <= 0;
            vm_dout <= '0;
        end else if (vec_get || vec_insert) begin
            if (vec_insert) vm_mem[vec_index] <= vec_data_in;
            else            vm_dout <= vm_mem[vec_index];
            vm_rdy <= (vm_lat <= 1);
            vm_cnt <= vm_lat - 1;
        end else if (vm_cnt > 1) begin
            vm_cnt <= vm_cnt - 1;
        end else begin
            vm_cnt <= 0;
            vm_rdy <= ~vm_stuck;
        end
    end

    // Reference state
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_dout = '0;
    bit            last_win = 1'b1;
    int            n_vec = 0;
    int            n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        exp_dout = '0;
        last_win = 1'b1;
    endtask

    // One transaction from a single requester, checked against the model.
    task automatic do_txn(input bit who, input bit ins, input logic [IW-1:0] idx,
                          input logic [DW-1:0] din, input int lat, input bit stuck, input string tag);
        int done_cyc = -1;
        int n_done = 0;
        int n_strobe = 0;
        int exp_lat;
        bit s_ins = 1'b0;
        bit hold_ok = 1'b1;
        bit dout_held = 1'b1;
        logic [IW-1:0] s_idx = '0;
        logic [DW-1:0] s_din = '0;
        exp_lat = stuck ? (3 + TO) : ((lat + 2 > 4) ? lat + 2 : 4);
        vm_lat = lat;
        if (!who) begin a_req = 1'b1; a_insert = ins; a_index = idx; a_data_in = din; end
        else      begin b_req = 1'b1; b_insert = ins; b_index = idx; b_data_in = din; end
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (vec_get || vec_insert) begin
                n_strobe++; s_ins = vec_insert; s_idx = vec_index; s_din = vec_data_in;
            end
            if (who ? b_grant : a_grant)
                hold_ok &= (vec_index === idx) && (vec_data_in === din);
            if (done_cyc < 0 && !(who ? b_done : a_done) && data_out !== exp_dout) dout_held = 1'b0;
            if (n == 1) begin
                if (stuck) vm_stuck = 1'b1;
                // Operands changed after grant must be ignored.
                if (!who) begin a_insert = ~ins; a_index = ~idx; a_data_in = ~din; end
                else      begin b_insert = ~ins; b_index = ~idx; b_data_in = ~din; end
            end
            if (who ? b_done : a_done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = n; a_req = 1'b0; b_req = 1'b0; vm_stuck = 1'b0;
                end
            end
            if (done_cyc > 0 && n >= done_cyc + 3) break;
        end
        a_req = 1'b0; b_req = 1'b0; vm_stuck = 1'b0;
        if (ins) ref_mem[idx] = din;
        else if (!stuck) exp_dout = ref_mem[idx];
        last_win = who;
        check($sformatf("%s.latency", tag), done_cyc, exp_lat);
        check($sformatf("%s.dones", tag), n_done, 1);
        check($sformatf("%s.strobes", tag), n_strobe, 1);
        check($sformatf("%s.op", tag), s_ins, ins);
        check($sformatf("%s.index", tag), s_idx, idx);
        check($sformatf("%s.wdata", tag), s_din, din);
        check($sformatf("%s.hold", tag), hold_ok, 1);
        check($sformatf("%s.dout_pre", tag), dout_held, 1);
        check($sformatf("%s.dout", tag), data_out, exp_dout);
        check($sformatf("%s.idle", tag), {busy, a_grant, b_grant}, 3'b000);
    endtask

    typedef struct {
        bit            who;
        bit            ins;
        logic [IW-1:0] idx;
        logic [DW-1:0] din;
        int            lat;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int  got;
        bit  bad_excl;
        bit  seen;
        bit  w;
        bit  exp_w;

        tbl[0] = '{who: 1'b0, ins: 1'b1, idx: 8'd5,   din: 17'h00123, lat: 3, dout: 17'h00000};
        tbl[1] = '{who: 1'b1, ins: 1'b1, idx: 8'd9,   din: 17'h1ABCD, lat: 1, dout: 17'h00000};
        tbl[2] = '{who: 1'b1, ins: 1'b0, idx: 8'd9,   din: 17'h00055, lat: 4, dout: 17'h1ABCD};
        tbl[3] = '{who: 1'b0, ins: 1'b0, idx: 8'd5,   din: 17'h00000, lat: 2, dout: 17'h00123};
        tbl[4] = '{who: 1'b0, ins: 1'b1, idx: 8'd255, din: 17'h1FFFF, lat: 6, dout: 17'h00123};
        tbl[5] = '{who: 1'b1, ins: 1'b0, idx: 8'd255, din: 17'h0AAAA, lat: 5, dout: 17'h1FFFF};
        tbl[6] = '{who: 1'b1, ins: 1'b0, idx: 8'd7,   din: 17'h00001, lat: 1, dout: 17'h00000};

        clear_ref();
        repeat (3) @(negedge clk);
        check("reset.outs", {a_grant, b_grant, a_done, b_done, vec_get, vec_insert, busy,
                             timeout_err, vec_index, vec_data_in, data_out}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i].who, tbl[i].ins, tbl[i].idx, tbl[i].din, tbl[i].lat, 1'b0,
                   $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.table_dout", i), data_out, tbl[i].dout);
        end

        // Both requesters held for four back-to-back transactions.
        a_insert = 1'b0; b_insert = 1'b0; a_index = 8'd5; b_index = 8'd9; vm_lat = 2;
        a_req = 1'b1; b_req = 1'b1;
        got = 0; bad_excl = 1'b0;
        for (int n = 0; n < 200 && got < 4; n++) begin
            @(negedge clk);
            if ((a_grant && b_grant) || (a_done && b_done)) bad_excl = 1'b1;
            if (a_done || b_done) begin
                w = b_done;
                exp_w = RR ? ~last_win : 1'b0;
                check($sformatf("tie%0d.winner", got), w, exp_w);
                last_win = w;
                exp_dout = ref_mem[w ? 9 : 5];
                got++;
                if (got == 4) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        check("tie.count", got, 4);
        check("tie.exclusive", bad_excl, 0);
        repeat (3) @(negedge clk);
        check("tie.dout", data_out, exp_dout);

        // Watchdog: vector never returns ready.
        check("timeout.pre", timeout_err, 0);
        do_txn(1'b0, 1'b0, 8'd9, 17'h00000, 2, 1'b1, "timeout");
        check("timeout.flag", timeout_err, 1);
        do_txn(1'b1, 1'b1, 8'd3, 17'h03333, 3, 1'b0, "post_timeout");
        check("timeout.sticky", timeout_err, 1);

        // Request pulsed while the vector is not ready.
        vm_block = 1'b1;
        @(negedge clk);
        a_req = 1'b1; a_insert = 1'b1; a_index = 8'd1;
        seen = 1'b0;
        @(negedge clk);
        a_req = 1'b0;
        for (int n = 0; n < 4; n++) begin
            seen |= a_grant | b_grant | vec_get | vec_insert | busy;
            @(negedge clk);
        end
        check("noready.quiet", seen, 0);
        vm_block = 1'b0;
        @(negedge clk);

        // Random single-requester transactions.
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)),
                   DW'($urandom), $urandom_range(1, 6), 1'b0, $sformatf("rnd%0d", i));
        end

        // Reset while B's transaction sits in WAIT.
        vm_lat = 12; b_insert = 1'b0; b_index = 8'd9; b_req = 1'b1;
        repeat (4) @(negedge clk);
        check("rstwait.pre", {b_grant, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rstwait.outs", {a_grant, b_grant, a_done, b_done, vec_get, vec_insert, busy,
                               timeout_err, vec_index, vec_data_in, data_out}, '0);
        b_req = 1'b0;
        clear_ref();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rstwait.idle", {busy, b_grant, timeout_err}, 3'b000);
        do_txn(1'b0, 1'b1, 8'd4, 17'h14444, 2, 1'b0, "post_reset_ins");
        do_txn(1'b1, 1'b0, 8'd4, 17'h00000, 3, 1'b0, "post_reset_get");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
